// File: rtl/drain_pkg.sv
// Shared types and defaults for the output SRAM drain engine.
package drain_pkg;

    localparam int NUM_BANKS_DEF = 32;
    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 10;
    localparam int BANK_W        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } drain_state_e;

    // One stream beat: data plus its source location and end-of-drain marker.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [BANK_W-1:0]     bank;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  last;
    } drain_beat_t;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO of drain beats. Push and pop may coincide, including when full.
module drain_skid_fifo
    import drain_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  drain_beat_t i_din,
    input  logic        i_pop,
    output logic [1:0]  o_count,
    output drain_beat_t o_head,
    output logic        o_empty
);

    drain_beat_t r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Storage, pointers and occupancy; storage cleared so an empty head reads 0 after reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/output_sram_drain.sv
// Drains output SRAM banks bank-major into a valid/ready word stream.
// Optional build macro DRAIN_CHECKSUM_EN adds o_checksum (sum of accepted words).
module output_sram_drain
    import drain_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [ADDR_W-1:0]           i_base_addr,
    input  logic [ADDR_W:0]             i_word_num,
    input  logic [5:0]                  i_bank_num,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [NUM_BANKS-1:0]        o_sram_cs,
    output logic                        o_sram_oe,
    output logic [ADDR_W-1:0]           o_sram_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] i_sram_rdata,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [DATA_W-1:0]           o_out_data,
    output logic [4:0]                  o_out_bank,
    output logic [ADDR_W-1:0]           o_out_addr,
    output logic                        o_out_last
`ifdef DRAIN_CHECKSUM_EN
    ,
    output logic [31:0]                 o_checksum
`endif
);

    drain_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_words;
    logic [5:0]        r_banks;
    logic [BANK_W-1:0] r_bank_idx;
    logic [ADDR_W:0]   r_word_idx;
    logic              r_inflight;
    logic [BANK_W-1:0] r_if_bank;
    logic [ADDR_W-1:0] r_if_addr;
    logic              r_if_last;

    logic              w_launch;
    logic [5:0]        w_banks_clamped;
    logic              w_pop;
    logic              w_room;
    logic              w_issue;
    logic              w_last_word;
    logic              w_last_rd;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_empty;
    drain_beat_t       w_din;
    drain_beat_t       w_head;

    assign w_launch        = (r_state == IDLE) && i_start;
    assign w_banks_clamped = (i_bank_num > 6'(NUM_BANKS)) ? 6'(NUM_BANKS) : i_bank_num;
    assign w_pop           = !w_fifo_empty && i_out_ready;
    // Count the popped slot as free so a full-rate stream keeps issuing every cycle.
    assign w_room          = ({1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2;
    assign w_issue         = (r_state == ISSUE) && w_room;
    assign w_last_word     = (r_word_idx == r_words - (ADDR_W+1)'(1));
    assign w_last_rd       = w_issue && w_last_word && ({1'b0, r_bank_idx} == r_banks - 6'd1);
    assign w_rd_addr       = r_base + r_word_idx[ADDR_W-1:0];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and status outputs; the final beat's handshake closes the drain.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start)
                    w_state_nxt = ((i_word_num == '0) || (w_banks_clamped == 6'd0)) ? FIN : ISSUE;
            end
            ISSUE: begin
                o_busy = 1'b1;
                if (w_last_rd) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                o_busy = 1'b1;
                if (w_pop && w_head.last) w_state_nxt = FIN;
            end
            FIN: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Drain parameters, read cursor and the one-deep in-flight read tag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_base     <= '0;
            r_words    <= '0;
            r_banks    <= '0;
            r_bank_idx <= '0;
            r_word_idx <= '0;
            r_inflight <= 1'b0;
            r_if_bank  <= '0;
            r_if_addr  <= '0;
            r_if_last  <= 1'b0;
        end else begin
            if (w_launch) begin
                r_base     <= i_base_addr;
                r_words    <= i_word_num;
                r_banks    <= w_banks_clamped;
                r_bank_idx <= '0;
                r_word_idx <= '0;
            end else if (w_issue) begin
                if (w_last_word) begin
                    r_word_idx <= '0;
                    r_bank_idx <= r_bank_idx + BANK_W'(1);
                end else begin
                    r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
                end
            end
            r_inflight <= w_issue;
            r_if_bank  <= r_bank_idx;
            r_if_addr  <= w_rd_addr;
            r_if_last  <= w_last_rd;
        end
    end

    // Tag the returning read data with where it came from.
    always_comb begin
        w_din      = '0;
        w_din.data = i_sram_rdata[r_if_bank*DATA_W +: DATA_W];
        w_din.bank = r_if_bank;
        w_din.addr = r_if_addr;
        w_din.last = r_if_last;
    end

    drain_skid_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_head  (w_head),
        .o_empty (w_fifo_empty)
    );

    assign o_sram_oe   = w_issue;
    assign o_sram_cs   = w_issue ? ({{(NUM_BANKS-1){1'b0}}, 1'b1} << r_bank_idx) : '0;
    assign o_sram_addr = w_issue ? w_rd_addr : '0;
    assign o_out_valid = !w_fifo_empty;
    assign o_out_data  = w_head.data;
    assign o_out_bank  = w_head.bank;
    assign o_out_addr  = w_head.addr;
    assign o_out_last  = w_head.last;

`ifdef DRAIN_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of accepted words; cleared when a drain launches, held after done.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)        r_checksum <= '0;
        else if (w_launch) r_checksum <= '0;
        else if (w_pop)    r_checksum <= r_checksum + 32'(o_out_data);
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_output_sram_drain.sv
// Self-checking bench for output_sram_drain: random SRAM contents, reference beat list
// computed from the bank-major ordering rules, per-scenario inline checks.
module tb_output_sram_drain;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  bank;
        logic [9:0]  addr;
        logic        last;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [9:0]   base_addr;
    logic [10:0]  word_num;
    logic [5:0]   bank_num;
    logic         busy, done;
    logic [31:0]  sram_cs;
    logic         sram_oe;
    logic [9:0]   sram_addr;
    logic [511:0] sram_rdata;
    logic         out_valid, out_ready;
    logic [15:0]  out_data;
    logic [4:0]   out_bank;
    logic [9:0]   out_addr;
    logic         out_last;
`ifdef DRAIN_CHECKSUM_EN
    logic [31:0]  checksum;
`endif

    output_sram_drain dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_word_num   (word_num),
        .i_bank_num   (bank_num),
        .o_busy       (busy),
        .o_done       (done),
        .o_sram_cs    (sram_cs),
        .o_sram_oe    (sram_oe),
        .o_sram_addr  (sram_addr),
        .i_sram_rdata (sram_rdata),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_bank   (out_bank),
        .o_out_addr   (out_addr),
        .o_out_last   (out_last)
`ifdef DRAIN_CHECKSUM_EN
        ,
        .o_checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank contents and a synchronous one-cycle read port; unselected slices carry noise.
    logic [15:0] mem [32][1024];
    always @(posedge clk) begin
        logic [511:0] rd;
        for (int b = 0; b < 32; b++)
            rd[b*16 +: 16] = (sram_oe && sram_cs[b]) ? mem[b][sram_addr] : 16'($urandom);
        sram_rdata <= rd;
    end

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    done_k, n_done, first_valid_k, reads, pops, max_out, stall_bad, cs_bad;
    bit    oe_seen, valid_seen, busy0, busy_at_done;

    // Reference: bank-major list of every word the drain must deliver.
    function automatic void build_exp(input logic [9:0] base, input int wn, input int bn);
        int    nb;
        int    a;
        beat_t e;
        nb = (bn > 32) ? 32 : bn;
        exp_q.delete();
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < wn; i++) begin
                a      = (int'(base) + i) % 1024;
                e.data = mem[b][a];
                e.bank = 5'(b);
                e.addr = 10'(a);
                e.last = (b == nb - 1) && (i == wn - 1);
                exp_q.push_back(e);
            end
    endfunction

    task automatic setup(input logic [9:0] base, input int wn, input int bn);
        base_addr = base;
        word_num  = 11'(wn);
        bank_num  = 6'(bn);
        build_exp(base, wn, (wn == 0) ? 0 : bn);
    endtask

    // Pulse start, step cycles recording accepted beats and protocol observations.
    // mode 0: ready high, 1: ready toggles 1,0,1,0, 2: random ready.
    task automatic run_drain(input int max_cyc, input int mode, input int restart_k);
        beat_t cur, prev;
        bit    prev_stall;
        got_q.delete();
        done_k = -1; n_done = 0; first_valid_k = -1; reads = 0; pops = 0;
        max_out = 0; stall_bad = 0; cs_bad = 0; oe_seen = 0; valid_seen = 0;
        busy0 = 0; busy_at_done = 0; prev_stall = 0; prev = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (k == restart_k) begin
                start     = 1'b1;
                base_addr = base_addr + 10'd100;
                word_num  = 11'd7;
                bank_num  = 6'd5;
            end else begin
                start = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom % 2);
            #1;
            cur = {out_data, out_bank, out_addr, out_last};
            if (k == 0) busy0 = busy;
            if (reads - pops > max_out) max_out = reads - pops;
            if (prev_stall && (!out_valid || cur !== prev)) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev       = cur;
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (out_valid) valid_seen = 1;
            if (sram_oe) begin
                oe_seen = 1;
                reads++;
                if (!$onehot(sram_cs)) cs_bad++;
            end else if (sram_cs != '0) begin
                cs_bad++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                pops++;
            end
            if (done) begin
                n_done++;
                if (busy) busy_at_done = 1;
                if (done_k < 0) done_k = k;
            end
            @(posedge clk); #1;
            if (done_k >= 0 && k >= done_k + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, sram_oe, out_valid, out_last} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b required=00000", {busy, done, sram_oe, out_valid, out_last});
        end
        n_cmp++;
        if ({sram_cs, sram_addr, out_data, out_bank, out_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_data got cs=%h addr=%h data=%h bank=%h oaddr=%h required all 0",
                     sram_cs, sram_addr, out_data, out_bank, out_addr);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        setup(10'h010, 3, 2);
        run_drain(40, 0, -1);
        n_cmp++;
        if (got_q.size() != 6) begin n_err++; $display("FAIL basic_count got=%0d required=6", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL basic_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (done_k != 8) begin n_err++; $display("FAIL basic_done_cycle got=%0d required=8", done_k); end
        n_cmp++;
        if (first_valid_k != 2) begin n_err++; $display("FAIL basic_first_valid got=%0d required=2", first_valid_k); end
        n_cmp++;
        if (!busy0 || busy_at_done || n_done != 1) begin
            n_err++; $display("FAIL basic_busy_done busy0=%0d busy_at_done=%0d ndone=%0d required 1/0/1",
                              busy0, busy_at_done, n_done);
        end
        n_cmp++;
        if (cs_bad != 0) begin n_err++; $display("FAIL basic_cs got=%0d bad cycles required=0", cs_bad); end
    endtask

    task automatic test_backpressure;
        setup(10'($urandom), 4, 4);
        run_drain(200, 1, -1);
        n_cmp++;
        if (got_q.size() != 16) begin n_err++; $display("FAIL bp_count got=%0d required=16", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (stall_bad != 0) begin n_err++; $display("FAIL bp_stable got=%0d unstable cycles required=0", stall_bad); end
        n_cmp++;
        if (max_out > 2) begin n_err++; $display("FAIL bp_outstanding got=%0d required<=2", max_out); end
        n_cmp++;
        if (n_done != 1) begin n_err++; $display("FAIL bp_done got=%0d pulses required=1", n_done); end
    endtask

    task automatic test_empty;
        setup(10'h055, 0, 3);
        run_drain(20, 0, -1);
        n_cmp++;
        if (oe_seen || valid_seen) begin
            n_err++; $display("FAIL empty_activity oe=%0d valid=%0d required 0/0", oe_seen, valid_seen);
        end
        n_cmp++;
        if (done_k != 0 || n_done != 1) begin
            n_err++; $display("FAIL empty_done cycle=%0d pulses=%0d required 0/1", done_k, n_done);
        end
        setup(10'h055, 5, 0);
        run_drain(20, 0, -1);
        n_cmp++;
        if (oe_seen || done_k != 0) begin
            n_err++; $display("FAIL empty_banks oe=%0d done_cycle=%0d required 0/0", oe_seen, done_k);
        end
    endtask

    task automatic test_wrap;
        logic [9:0] want [4];
        want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000; want[3] = 10'h001;
        setup(10'h3FE, 4, 1);
        run_drain(30, 0, -1);
        n_cmp++;
        if (got_q.size() != 4) begin n_err++; $display("FAIL wrap_count got=%0d required=4", got_q.size()); end
        for (int i = 0; i < 4; i++) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i].addr !== want[i] || got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL wrap_beat%0d got=%h required addr=%h beat=%h", i, got_q[i], want[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (done_k != 6) begin n_err++; $display("FAIL wrap_done_cycle got=%0d required=6", done_k); end
    endtask

    task automatic test_abort;
        int  cnt;
        bit  done_seen;
        setup(10'h000, 4, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1; cnt = 0;
        for (int k = 0; k < 50 && cnt < 5; k++) begin
            #1;
            if (out_valid) cnt++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cnt != 5) begin n_err++; $display("FAIL abort_prefix got=%0d beats required=5", cnt); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, sram_oe, sram_cs, sram_addr, out_valid, out_data, out_bank, out_addr, out_last} !== '0) begin
            n_err++; $display("FAIL abort_outputs got busy=%b oe=%b valid=%b data=%h required all 0",
                              busy, sram_oe, out_valid, out_data);
        end
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) done_seen = 1;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (done || busy) done_seen = 1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done_seen) begin n_err++; $display("FAIL abort_no_done got done/busy after reset required none"); end
        setup(10'($urandom), 3, 2);
        run_drain(40, 0, -1);
        n_cmp++;
        if (got_q.size() != exp_q.size() || n_done != 1) begin
            n_err++; $display("FAIL abort_restart got=%0d beats %0d dones required=%0d/1", got_q.size(), n_done, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL abort_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        setup(10'h020, 4, 1);
        run_drain(40, 0, 2);
        n_cmp++;
        if (got_q.size() != 4 || n_done != 1 || done_k != 6) begin
            n_err++; $display("FAIL busy_start got=%0d beats %0d dones at %0d required 4/1/6", got_q.size(), n_done, done_k);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL busy_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clamp;
        setup(10'($urandom), 2, 40);
        run_drain(200, 0, -1);
        n_cmp++;
        if (got_q.size() != 64 || done_k != 66) begin
            n_err++; $display("FAIL clamp_count got=%0d beats done at %0d required 64/66", got_q.size(), done_k);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL clamp_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            setup(10'($urandom), 1 + int'($urandom_range(0, 5)), 1 + int'($urandom_range(0, 4)));
            run_drain(300, 2, -1);
            n_cmp++;
            if (got_q.size() != exp_q.size() || n_done != 1) begin
                n_err++; $display("FAIL rand%0d_count got=%0d beats %0d dones required=%0d/1",
                                  it, got_q.size(), n_done, exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rand%0d_beat%0d got=%h required=%h", it, i, got_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (stall_bad != 0 || max_out > 2 || cs_bad != 0) begin
                n_err++; $display("FAIL rand%0d_protocol got stall=%0d outstanding=%0d cs=%0d required 0/<=2/0",
                                  it, stall_bad, max_out, cs_bad);
            end
        end
    endtask

`ifdef DRAIN_CHECKSUM_EN
    task automatic test_checksum;
        for (int i = 0; i < 8; i++) mem[0][i] = 16'(i + 1);
        setup(10'h000, 8, 1);
        run_drain(40, 1, -1);
        n_cmp++;
        if (checksum !== 32'd36) begin n_err++; $display("FAIL checksum got=%0d required=36", checksum); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_num = '0; bank_num = '0;
        for (int b = 0; b < 32; b++)
            for (int a = 0; a < 1024; a++) mem[b][a] = 16'($urandom);
        test_reset;
        test_basic;
        test_backpressure;
        test_empty;
        test_wrap;
        test_abort;
        test_start_while_busy;
        test_clamp;
        test_random;
`ifdef DRAIN_CHECKSUM_EN
        test_checksum;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
